// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback block.
// Supplies a 32-bit default for WORD_WIDTH when the build does not define one.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package regfile_wb_pkg;

    // The request struct is sized for the widest supported configuration.
    // Users zero-extend into it and slice back out to their own widths.
    localparam int WB_ADDR_MAX = 16;
    localparam int WB_DATA_MAX = 64;

    // ALU wins arbitration once it has been refused this many cycles in a row.
    localparam logic [1:0] STARVE_LIMIT = 2'd3;

    typedef struct packed {
        logic [WB_ADDR_MAX-1:0] addr;
        logic [WB_DATA_MAX-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bitmap. Issue sets a bit and writeback clears it.
// When both hit the same bit in one cycle, the set takes priority.
module regfile_scoreboard #(
    parameter int COUNT          = 32,
    parameter int ADDR_WIDTH     = $clog2(COUNT),
    parameter bit ZERO_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [COUNT-1:0]      pending
);

    logic [COUNT-1:0] pending_q;
    logic [COUNT-1:0] pending_d;

    // An address at or above COUNT matches no bit, so it is ignored with no extra logic.
    genvar gi;
    generate
        for (gi = 0; gi < COUNT; gi++) begin : g_bit
            localparam bit READ_ONLY = ZERO_HARDWIRED && (gi == 0);
            logic set_hit;
            logic clr_hit;
            assign set_hit = set_en && (set_addr == ADDR_WIDTH'(gi)) && !READ_ONLY;
            assign clr_hit = clr_en && (clr_addr == ADDR_WIDTH'(gi));
            assign pending_d[gi] = set_hit || (pending_q[gi] && !clr_hit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/regfile_wb.sv
// Writeback arbiter (ALU vs load) with a registered write port and a pending scoreboard.
// Define REGFILE_WB_FWD_EN to enable write-port forwarding comparators.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int   WIDTH          = `WORD_WIDTH,
    parameter int   COUNT          = 32,
    parameter bit   ZERO_HARDWIRED = 1'b1,
    localparam int  ADDR_WIDTH     = $clog2(COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_addr,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_data,
    output logic                  we_d,
    output logic [ADDR_WIDTH-1:0] addr_d,
    output logic [WIDTH-1:0]      d,
    output logic [COUNT-1:0]      pending,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  fwd_a_hit,
    output logic                  fwd_b_hit,
    output logic [WIDTH-1:0]      fwd_a,
    output logic [WIDTH-1:0]      fwd_b
);

    logic [1:0]            starve_q, starve_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [WIDTH-1:0]      wr_data_q;

    logic                  alu_win, alu_xfer, mem_xfer, xfer;
    logic                  addr_ok, zero_blk;
    wb_req_t               req_sel;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_data;

    // The grant depends only on the valids and the starvation count, never on addr or data.
    assign alu_win   = alu_valid && (!mem_valid || (starve_q == STARVE_LIMIT));
    assign alu_ready = !rst && alu_win;
    assign mem_ready = !rst && mem_valid && !alu_win;
    assign alu_xfer  = alu_valid && alu_ready;
    assign mem_xfer  = mem_valid && mem_ready;
    assign xfer      = alu_xfer || mem_xfer;

    always_comb begin
        starve_d     = starve_q;
        req_sel.addr = WB_ADDR_MAX'(alu_addr);
        req_sel.data = WB_DATA_MAX'(alu_data);
        if (!alu_valid || alu_xfer) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIMIT) begin
            starve_d = starve_q + 2'd1;
        end
        if (mem_xfer) begin
            req_sel.addr = WB_ADDR_MAX'(mem_addr);
            req_sel.data = WB_DATA_MAX'(mem_data);
        end
    end

    assign sel_addr = req_sel.addr[ADDR_WIDTH-1:0];
    assign sel_data = req_sel.data[WIDTH-1:0];
    // The upper bits of the request only hold zero-extension padding.
    wire unused_req = ^req_sel;

    // A write to an out-of-range or hardwired-zero register is accepted but not performed.
    assign addr_ok  = {1'b0, sel_addr} < (ADDR_WIDTH+1)'(COUNT);
    assign zero_blk = ZERO_HARDWIRED && (sel_addr == '0);
    assign wr_en_d  = xfer && addr_ok && !zero_blk;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            starve_q <= starve_d;
            wr_en_q  <= wr_en_d;
            if (xfer) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
            end
        end
    end

    assign we_d   = wr_en_q;
    assign addr_d = wr_addr_q;
    assign d      = wr_data_q;

    regfile_scoreboard #(
        .COUNT          (COUNT),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .ZERO_HARDWIRED (ZERO_HARDWIRED)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_valid),
        .set_addr (iss_addr),
        .clr_en   (wr_en_q),
        .clr_addr (wr_addr_q),
        .pending  (pending)
    );

`ifdef REGFILE_WB_FWD_EN
    assign fwd_a_hit = wr_en_q && (wr_addr_q == rd_addr_a);
    assign fwd_b_hit = wr_en_q && (wr_addr_q == rd_addr_b);
    assign fwd_a     = wr_data_q;
    assign fwd_b     = wr_data_q;
`else
    assign fwd_a_hit = 1'b0;
    assign fwd_b_hit = 1'b0;
    assign fwd_a     = '0;
    assign fwd_b     = '0;
    wire unused_rd_addr = ^{rd_addr_a, rd_addr_b};
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: reset, handshakes, arbitration, scoreboard, zero register, forwarding.
// Expected values are hand-computed constants; inputs are driven 1 time unit after the rising edge.
`timescale 1ns/1ps
module tb_regfile_wb;

    localparam int WIDTH = 32;
    localparam int COUNT = 32;
    localparam int AW    = 5;
    localparam int NV    = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic             alu_valid, alu_ready;
    logic [AW-1:0]    alu_addr;
    logic [WIDTH-1:0] alu_data;
    logic             mem_valid, mem_ready;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             we_d;
    logic [AW-1:0]    addr_d;
    logic [WIDTH-1:0] d;
    logic [COUNT-1:0] pending;
    logic [AW-1:0]    rd_addr_a, rd_addr_b;
    logic             fwd_a_hit, fwd_b_hit;
    logic [WIDTH-1:0] fwd_a, fwd_b;

    int checks   = 0;
    int failures = 0;

    // {alu_valid, mem_valid, expected alu_ready, expected mem_ready}
    logic [3:0] arb_vec [NV] = '{
        4'b1101, 4'b1101, 4'b1101, 4'b1110,
        4'b1101, 4'b1101, 4'b1101, 4'b1110,
        4'b1101, 4'b1101, 4'b0101,
        4'b1101, 4'b1101, 4'b1101, 4'b1110,
        4'b0000, 4'b1010
    };

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .we_d      (we_d),
        .addr_d    (addr_d),
        .d         (d),
        .pending   (pending),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .fwd_a_hit (fwd_a_hit),
        .fwd_b_hit (fwd_b_hit),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input string tag, input logic exp_we, input logic [AW-1:0] exp_addr,
                             input logic [WIDTH-1:0] exp_data);
        check({tag, "_we"},   64'(we_d),   64'(exp_we));
        check({tag, "_addr"}, 64'(addr_d), 64'(exp_addr));
        check({tag, "_data"}, 64'(d),      64'(exp_data));
    endtask

    logic          av, mv, ar, mr;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_data;

    initial begin
        rst = 1'b1; iss_valid = 1'b0; iss_addr = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h0000_4444;
        rd_addr_a = '0; rd_addr_b = '0;
        iss_valid = 1'b1; iss_addr = 5'd3;
        #1;
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        tick(); tick();
        $display("txn reset with mem_valid and iss_valid held");
        expect_wb("rst", 1'b0, 5'd0, 32'd0);
        check("rst_pending", 64'(pending), 64'd0);
        rst = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
        tick();
        check("post_rst_we", 64'(we_d), 64'd0);

        // Single ALU transfer, one-cycle latency, then idle.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        check("alu_only_alu_ready", 64'(alu_ready), 64'd1);
        check("alu_only_mem_ready", 64'(mem_ready), 64'd0);
        tick();
        alu_valid = 1'b0;
        $display("txn alu addr=5 data=deadbeef");
        expect_wb("alu_n1", 1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        expect_wb("alu_n2", 1'b0, 5'd5, 32'hDEAD_BEEF);

        // Single MEM transfer.
        mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'hCAFE_0001;
        #1;
        check("mem_only_mem_ready", 64'(mem_ready), 64'd1);
        check("mem_only_alu_ready", 64'(alu_ready), 64'd0);
        tick();
        mem_valid = 1'b0;
        $display("txn mem addr=12 data=cafe0001");
        expect_wb("mem_n1", 1'b1, 5'd12, 32'hCAFE_0001);

        // Arbitration table: MEM wins three times, then a starved ALU wins.
        exp_addr = 5'd12; exp_data = 32'hCAFE_0001;
        for (int i = 0; i < NV; i++) begin
            {av, mv, ar, mr} = arb_vec[i];
            alu_valid = av; alu_addr = 5'd1; alu_data = 32'h1111_0001;
            mem_valid = mv; mem_addr = 5'd2; mem_data = 32'h2222_0002;
            #1;
            check($sformatf("arb%0d_alu_ready", i), 64'(alu_ready), 64'(ar));
            check($sformatf("arb%0d_mem_ready", i), 64'(mem_ready), 64'(mr));
            tick();
            if (ar) begin
                exp_addr = 5'd1; exp_data = 32'h1111_0001;
            end else if (mr) begin
                exp_addr = 5'd2; exp_data = 32'h2222_0002;
            end
            $display("txn arb %0d alu_v=%0b mem_v=%0b alu_r=%0b mem_r=%0b", i, av, mv, alu_ready, mem_ready);
            expect_wb($sformatf("arb%0d", i), ar | mr, exp_addr, exp_data);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;

        // Scoreboard: set, idempotent re-issue, clear after the write cycle.
        iss_valid = 1'b1; iss_addr = 5'd7;
        tick();
        $display("txn issue r7");
        check("sb_set7", 64'(pending), 64'h80);
        tick();
        iss_valid = 1'b0;
        check("sb_reissue7", 64'(pending), 64'h80);
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h0000_7777;
        tick();
        alu_valid = 1'b0;
        $display("txn alu writeback r7");
        check("sb_we7", 64'(we_d), 64'd1);
        check("sb_during_we7", 64'(pending), 64'h80);
        tick();
        check("sb_cleared7", 64'(pending), 64'h0);

        // Set wins over a clear of the same bit.
        iss_valid = 1'b1; iss_addr = 5'd7;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h0000_7778;
        tick();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_addr = 5'd7;
        tick();
        iss_valid = 1'b0;
        $display("txn issue r7 coincident with we_d r7");
        check("sb_set_wins", 64'(pending), 64'h80);
        tick();
        check("sb_set_wins_hold", 64'(pending), 64'h80);

        // Independent set and clear in the same cycles.
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h0000_7779;
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        alu_valid = 1'b0; iss_valid = 1'b0;
        $display("txn alu writeback r7 with issue r3");
        check("sb_mix_a", 64'(pending), 64'h88);
        check("sb_mix_addr", 64'(addr_d), 64'd7);
        tick();
        check("sb_mix_b", 64'(pending), 64'h08);

        // Register 0 is hardwired: accepted, never written, never pending.
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h0000_1234;
        iss_valid = 1'b1; iss_addr = 5'd0;
        #1;
        check("zero_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0; iss_valid = 1'b0;
        $display("txn alu addr=0 data=1234");
        check("zero_we", 64'(we_d), 64'd0);
        check("zero_pending", 64'(pending), 64'h08);

        // Forwarding on a write to r9.
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h9999_0009;
        tick();
        alu_valid = 1'b0;
        rd_addr_a = 5'd9; rd_addr_b = 5'd3;
        #1;
        $display("txn alu writeback r9 with rd_a=9 rd_b=3");
        check("fwd_we", 64'(we_d), 64'd1);
`ifdef REGFILE_WB_FWD_EN
        check("fwd_a_hit", 64'(fwd_a_hit), 64'd1);
        check("fwd_a",     64'(fwd_a),     64'h9999_0009);
        check("fwd_b_hit", 64'(fwd_b_hit), 64'd0);
        check("fwd_b",     64'(fwd_b),     64'h9999_0009);
`else
        check("fwd_a_hit", 64'(fwd_a_hit), 64'd0);
        check("fwd_a",     64'(fwd_a),     64'd0);
        check("fwd_b_hit", 64'(fwd_b_hit), 64'd0);
        check("fwd_b",     64'(fwd_b),     64'd0);
`endif
        tick();

        // Reset mid-stream discards the pending transfer and the scoreboard.
        rst = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h0000_00AA;
        mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h0000_00BB;
        #1;
        check("rst2_alu_ready", 64'(alu_ready), 64'd0);
        check("rst2_mem_ready", 64'(mem_ready), 64'd0);
        tick();
        rst = 1'b0; alu_valid = 1'b0;
        $display("txn reset with both channels valid");
        expect_wb("rst2", 1'b0, 5'd0, 32'd0);
        check("rst2_pending", 64'(pending), 64'd0);

        // First transfer right after reset release.
        #1;
        check("post_rst2_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        mem_valid = 1'b0;
        $display("txn mem addr=6 data=bb after reset");
        expect_wb("post_rst2", 1'b1, 5'd6, 32'h0000_00BB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 SHALL have parameter WIDTH, default `WORD_WIDTH, data word width.
REQ-002 SHALL have parameter COUNT, default 32, number of registers; ADDR_WIDTH = $clog2(COUNT) is a derived localparam.
REQ-003 SHALL have parameter ZERO_HARDWIRED, default 1, register 0 is read-only zero.
REQ-004 SHALL have ports, one clock, synchronous active-high reset:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- iss_valid  in  1  decode issued an instruction writing iss_addr.
- iss_addr  in  ADDR_WIDTH  destination register of the issued instruction.
- alu_valid / alu_ready  in / out  1  ALU result handshake.
- alu_addr, alu_data  in  ADDR_WIDTH, WIDTH  ALU result destination and value.
- mem_valid / mem_ready  in / out  1  load result handshake.
- mem_addr, mem_data  in  ADDR_WIDTH, WIDTH  load result destination and value.
- we_d, addr_d, d  out  1, ADDR_WIDTH, WIDTH  register file write port.
- pending  out  COUNT  scoreboard; bit i set means a write to register i is outstanding.
- rd_addr_a, rd_addr_b  in  ADDR_WIDTH  decode read addresses, for forwarding.
- fwd_a_hit, fwd_b_hit  out  1  the value being written this cycle matches rd_addr_a / rd_addr_b.
- fwd_a, fwd_b  out  WIDTH  forwarded data.

Function
REQ-005 A transfer SHALL occur on a channel in a cycle where valid && ready; ready SHALL NOT depend on the channel's own addr or data.
REQ-006 At most one channel SHALL be ready per cycle; MEM wins by default.
REQ-007 A 2-bit starvation counter SHALL count consecutive cycles with alu_valid high and no ALU transfer; at value 3 ALU wins; the counter clears on an ALU transfer or when alu_valid is low.
REQ-008 When only one channel is valid, that channel SHALL be ready; when neither is valid, both readys SHALL be 0.
REQ-009 A transfer in cycle N SHALL drive we_d=1, addr_d and d with the transferred values in cycle N+1 (registered, 1-cycle latency, full throughput).
REQ-010 we_d SHALL be 0 in any cycle following a cycle with no transfer; addr_d and d hold their last values.
REQ-011 With ZERO_HARDWIRED=1, a transfer to address 0 SHALL be accepted but SHALL produce we_d=0.
REQ-012 iss_valid in cycle N SHALL set pending[iss_addr] at the end of cycle N; with ZERO_HARDWIRED=1, bit 0 is never set.
REQ-013 we_d=1 in cycle N SHALL clear pending[addr_d] at the end of cycle N.
REQ-014 If a set and a clear target the same bit in the same cycle, the set SHALL win.
REQ-015 Issuing to an already-pending register SHALL leave its bit set; no counting.
REQ-016 Addresses >= COUNT (non-power-of-two COUNT) SHALL be ignored for pending updates and SHALL produce we_d=0.

Reset
REQ-017 While rst is high at a posedge, the block SHALL clear we_d, addr_d, d, pending and the starvation counter to 0.
REQ-018 alu_ready and mem_ready SHALL be 0 in any cycle where rst is high.
REQ-019 A transfer coincident with rst SHALL be discarded.
REQ-020 Reset SHALL NOT require clk gating; the first transfer is possible in the cycle after rst deasserts.

Configuration
REQ-021 Macro REGFILE_WB_FWD_EN defined: fwd_x_hit = we_d && (addr_d == rd_addr_x), and fwd_x = d, combinationally.
REQ-022 Macro REGFILE_WB_FWD_EN undefined: fwd_a_hit, fwd_b_hit, fwd_a and fwd_b SHALL be tied to 0 and no comparators SHALL be synthesised.

Structure
REQ-023 A shared core package SHALL hold the wb_req_t struct {addr, data} and the starvation threshold constant (3).
REQ-024 One sub-module, regfile_scoreboard (pending bitmap, set/clear, set-wins rule), SHALL be instantiated; arbitration and the output register are in regfile_wb.

Verification
REQ-025 ALU-only transfer, alu addr=5, data=0xDEADBEEF, cycle N -> cycle N+1: we_d=1, addr_d=5, d=0xDEADBEEF; cycle N+2: we_d=0.
REQ-026 Both channels valid continuously -> MEM is ready for 3 cycles, ALU is ready on the 4th cycle, then the pattern repeats.
REQ-027 Issue to reg 7 -> pending[7]=1; writeback to 7 -> cleared after the we_d cycle; issue to 7 in the same cycle as we_d to 7 -> pending[7] stays 1.
REQ-028 Transfer to address 0 with data 0x1234 and ZERO_HARDWIRED=1 -> we_d stays 0 and pending[0] stays 0.
REQ-029 rst asserted while mem_valid=1 -> mem_ready=0, and the next cycle has we_d=0 and pending=0.
REQ-030 With REGFILE_WB_FWD_EN, we_d to 9 with rd_addr_a=9 and rd_addr_b=3 -> fwd_a_hit=1, fwd_a=d, fwd_b_hit=0; with the macro undefined, all forwarding outputs stay 0.
